// File: rtl/m2_serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b LSB-first, one bit per clock, WIDTH cycles start-to-done.
// No backpressure: start_i is only honoured while idle and is silently dropped while busy.
module m2_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic            borrow;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            last_bit;
  logic            d_bit;
  logic            b_next;

  // Operands shift right, so the bit being processed is always at position 0.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_bit   = 1'b0;
    d_bit      = a_sh[0] ^ b_sh[0] ^ borrow;
    b_next     = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
    case (state)
      IDLE: begin
        if (start_i) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last_bit   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      done_o <= 1'b0;
      diff_o <= '0;
      bout_o <= 1'b0;
    end else begin
      done_o <= last_bit;
      if (accept) begin
        a_sh   <= a_i;
        b_sh   <= b_i;
        res    <= '0;
        borrow <= 1'b0;
        cnt    <= '0;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res    <= {d_bit, res[WIDTH-1:1]};
        borrow <= b_next;
        cnt    <= cnt + CW'(1);
        // Final bit completes the word; results hold until the next completion.
        if (last_bit) begin
          diff_o <= {d_bit, res[WIDTH-1:1]};
          bout_o <= b_next;
        end
      end
    end
  end

  assign busy_o = (state == RUN);

endmodule

// File: tb/tb_m2_serial_subtractor.sv
// Bench for m2_serial_subtractor (WIDTH=8): vector table, multi-cycle corner sequences, random run.
module tb_m2_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  m2_serial_subtractor #(.WIDTH(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .a_i     (a_in),
    .b_i     (b_in),
    .busy_o  (busy),
    .done_o  (done),
    .diff_o  (diff),
    .bout_o  (bout)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One isolated operation: latency, busy window, result and single done pulse.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic eb, input string name);
    int n;
    int busy_n;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    tick();
    start = 1'b0;
    a_in  = 8'($urandom);
    b_in  = 8'($urandom);
    n = 0;
    busy_n = 0;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      tick();
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'd8);
    check({name, "_busy_cycles"}, 32'(busy_n), 32'd8);
    check({name, "_diff"}, 32'(diff), 32'(ed));
    check({name, "_bout"}, 32'(bout), 32'(eb));
    check({name, "_busy_at_done"}, 32'(busy), 32'd0);
    tick();
    check({name, "_done_single"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int m;
    int pulses;
    int busies;
    int gap;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] exp_d;
    logic       exp_b;

    vecs[0] = '{8'd5,    8'd3,    8'h02, 1'b0};
    vecs[1] = '{8'd3,    8'd5,    8'hFE, 1'b1};
    vecs[2] = '{8'd0,    8'd1,    8'hFF, 1'b1};
    vecs[3] = '{8'hFF,   8'hFF,   8'h00, 1'b0};
    vecs[4] = '{8'h80,   8'h01,   8'h7F, 1'b0};
    vecs[5] = '{8'hFF,   8'h00,   8'hFF, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    a_in  = 8'h00;
    b_in  = 8'h00;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_bout", 32'(bout), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, $sformatf("vec%0d", i));
    end

    // start_i and operand noise while busy must not disturb the in-flight op.
    start = 1'b1;
    a_in  = 8'd10;
    b_in  = 8'd4;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      if (n >= 2) begin
        start = 1'b1;
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
      end
      tick();
      n++;
    end
    start = 1'b0;
    check("ignore_latency", 32'(n), 32'd8);
    check("ignore_diff", 32'(diff), 32'h06);
    check("ignore_bout", 32'(bout), 32'd0);
    pulses = 0;
    busies = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) pulses++;
      if (busy) busies++;
    end
    check("ignore_no_second_done", 32'(pulses), 32'd0);
    check("ignore_no_second_busy", 32'(busies), 32'd0);

    // Mid-operation reset discards the result and suppresses done.
    start = 1'b1;
    a_in  = 8'd9;
    b_in  = 8'd7;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_diff", 32'(diff), 32'd0);
    check("midrst_bout", 32'(bout), 32'd0);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) pulses++;
    end
    check("midrst_no_done", 32'(pulses), 32'd0);
    do_op(8'd2, 8'd1, 8'h01, 1'b0, "after_rst");

    // Back-to-back: start held through the done cycle is accepted right after it.
    start = 1'b1;
    a_in  = 8'd20;
    b_in  = 8'd5;
    tick();
    a_in  = 8'd1;
    b_in  = 8'd3;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("b2b_first_latency", 32'(n), 32'd8);
    check("b2b_first_diff", 32'(diff), 32'h0F);
    check("b2b_first_bout", 32'(bout), 32'd0);
    tick();
    start = 1'b0;
    check("b2b_second_accepted", 32'(busy), 32'd1);
    m = 1;
    while (!done && m < 40) begin
      tick();
      m++;
    end
    check("b2b_spacing", 32'(m), 32'd9);
    check("b2b_second_diff", 32'(diff), 32'hFE);
    check("b2b_second_bout", 32'(bout), 32'd1);
    tick();

    // Random operands with random start gaps (gap 0 starts during the done cycle).
    for (int i = 0; i < 1000; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        start = 1'b0;
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
        tick();
      end
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      exp_d = 8'((int'(ra) - int'(rb) + 256) % 256);
      exp_b = (ra < rb);
      start = 1'b1;
      a_in  = ra;
      b_in  = rb;
      tick();
      n = 0;
      while (!done && n < 40) begin
        start = 1'($urandom_range(0, 1));
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
        tick();
        n++;
      end
      check($sformatf("rand%0d_latency", i), 32'(n), 32'd8);
      check($sformatf("rand%0d_diff", i), 32'(diff), 32'(exp_d));
      check($sformatf("rand%0d_bout", i), 32'(bout), 32'(exp_b));
    end
    start = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
